// File: rtl/cla_result_buffer.sv
// cla_result_buffer: result-capture stage behind a fixed-latency, non-stalling CLA.
// Issues are tracked through the adder latency by a valid delay line. Each emerging
// {c_out,sum} is pushed into a first-word fall-through FIFO. Credits keep the
// in-flight plus buffered total within DEPTH.
// Optional feature macro: CLA_RESULT_PARITY_EN adds a stored even-parity bit and o_parity.
module cla_result_buffer #(
    parameter int unsigned ADDER_LATENCY = 5,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned DATA_W        = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_issue_valid,
    output logic                       o_issue_ready,
    input  logic [DATA_W-1:0]          i_sum,
    input  logic                       i_c_out,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_W-1:0]          o_sum,
    output logic                       o_c_out,
    output logic [$clog2(DEPTH):0]     o_count,
`ifdef CLA_RESULT_PARITY_EN
    output logic                       o_parity,
`endif
    output logic                       o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef CLA_RESULT_PARITY_EN
    localparam int unsigned ENTRY_W = DATA_W + 2;
`else
    localparam int unsigned ENTRY_W = DATA_W + 1;
`endif

    logic [ADDER_LATENCY-1:0] r_vld_sr;
    logic [ENTRY_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [ENTRY_W-1:0]       r_last;
    logic                     r_overflow;

    logic                     w_accept;
    logic                     w_cap;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [31:0]              w_inflight;
    logic [ENTRY_W-1:0]       w_entry_in;
    logic [ENTRY_W-1:0]       w_head;
    logic [ENTRY_W-1:0]       w_out;

    assign w_accept = i_issue_valid & o_issue_ready;
    assign w_cap    = r_vld_sr[ADDER_LATENCY-1] & ~i_rst;
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign o_valid  = (r_count != '0);
    assign w_pop    = o_valid & i_ready;
    // A capture at full is only legal when a pop frees the slot in the same cycle.
    assign w_push   = w_cap & (~w_full | w_pop);
    assign w_drop   = w_cap & w_full & ~w_pop;

`ifdef CLA_RESULT_PARITY_EN
    assign w_entry_in = {^{i_c_out, i_sum}, i_c_out, i_sum};
`else
    assign w_entry_in = {i_c_out, i_sum};
`endif

    // Credit check: outstanding adds plus buffered results must stay below DEPTH.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < ADDER_LATENCY; i++) begin
            w_inflight = w_inflight + 32'(r_vld_sr[i]);
        end
        o_issue_ready = ~i_rst & ((w_inflight + 32'(r_count)) < 32'(DEPTH));
    end

    // Valid delay line tracking accepted issues through the adder latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_sr <= '0;
        end else begin
            for (int unsigned i = 1; i < ADDER_LATENCY; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
            r_vld_sr[0] <= w_accept;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Last popped entry, shown on the outputs while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    // Sticky protocol-violation flag: issue without credit, or capture into a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if ((i_issue_valid & ~o_issue_ready) | w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign w_out      = o_valid ? w_head : r_last;
    assign o_sum      = w_out[DATA_W-1:0];
    assign o_c_out    = w_out[DATA_W];
`ifdef CLA_RESULT_PARITY_EN
    assign o_parity   = w_out[DATA_W+1];
`endif
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_cla_result_buffer.sv
// Scoreboard bench for cla_result_buffer with a 5-stage behavioural adder in front.
module tb_cla_result_buffer;

    localparam int L     = 5;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
`ifdef CLA_RESULT_PARITY_EN
    localparam int EW = DW + 2;
`else
    localparam int EW = DW + 1;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_issue_valid = 1'b0;
    logic          o_issue_ready;
    logic [DW-1:0] i_sum;
    logic          i_c_out;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_sum;
    logic          o_c_out;
    logic [3:0]    o_count;
    logic          o_overflow;
`ifdef CLA_RESULT_PARITY_EN
    logic          o_parity;
`endif

    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic [DW:0]   pipe [L];

    logic [EW-1:0] sb [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_pops   = 0;

    always #5 clk = ~clk;

    cla_result_buffer #(.ADDER_LATENCY(L), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_issue_valid (i_issue_valid),
        .o_issue_ready (o_issue_ready),
        .i_sum         (i_sum),
        .i_c_out       (i_c_out),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sum         (o_sum),
        .o_c_out       (o_c_out),
        .o_count       (o_count),
`ifdef CLA_RESULT_PARITY_EN
        .o_parity      (o_parity),
`endif
        .o_overflow    (o_overflow)
    );

    // Behavioural adder: operands presented in a cycle emerge L cycles later.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign i_sum   = pipe[L-1][DW-1:0];
    assign i_c_out = pipe[L-1][DW];

    function automatic logic [EW-1:0] exp_entry(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef CLA_RESULT_PARITY_EN
        return {^s, s};
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: every accepted issue owes one result.
    always @(negedge clk) begin
        if (!i_rst && i_issue_valid && o_issue_ready) sb.push_back(exp_entry(op_a, op_b));
    end

    // Monitor: every consumer handshake must match the oldest outstanding result.
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        if (o_valid && i_ready) begin
            n_pops++;
`ifdef CLA_RESULT_PARITY_EN
            act = {o_parity, o_c_out, o_sum};
`else
            act = {o_c_out, o_sum};
`endif
            if (sb.size() == 0) begin
                check("unexpected_pop", 32'(act), 32'hDEAD_BEEF);
            end else begin
                exp = sb.pop_front();
                check("pop_data", 32'(act), 32'(exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int acc;
        int pops0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_sum", 32'(o_sum), 0);
        check("rst_cout", 32'(o_c_out), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        check("rst_ready_low", 32'(o_issue_ready), 0);
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_issue_ready), 1);

        // 1: single issue, latency and hold-after-pop
        tick();
        op_a = 16'h1234; op_b = 16'h0001; i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("lat_not_yet", 32'(o_valid), 0);
        tick();
        @(negedge clk);
        check("lat_valid", 32'(o_valid), 1);
        check("t1_sum", 32'(o_sum), 32'h1235);
        check("t1_cout", 32'(o_c_out), 0);
        check("t1_count", 32'(o_count), 1);
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        @(negedge clk);
        check("t1_empty", 32'(o_count), 0);
        check("t1_hold_sum", 32'(o_sum), 32'h1235);

        // 2: carry-out and parity
        op_a = 16'hFFFF; op_b = 16'h0001; i_issue_valid = 1'b1;
        tick();
        op_a = 16'h0003; op_b = 16'h0000;
        tick();
        i_issue_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t2_count", 32'(o_count), 2);
        check("t2_sum_a", 32'(o_sum), 32'h0000);
        check("t2_cout_a", 32'(o_c_out), 1);
`ifdef CLA_RESULT_PARITY_EN
        check("t2_par_a", 32'(o_parity), 1);
`endif
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        @(negedge clk);
        check("t2_sum_b", 32'(o_sum), 32'h0003);
        check("t2_cout_b", 32'(o_c_out), 0);
`ifdef CLA_RESULT_PARITY_EN
        check("t2_par_b", 32'(o_parity), 0);
`endif
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // 3: fill under credit with consumer stalled
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            op_a = 16'h1000 + 16'(i * 16'h1111);
            op_b = 16'(i);
            i_issue_valid = o_issue_ready;
            if (o_issue_ready) acc++;
            tick();
        end
        i_issue_valid = 1'b0;
        check("t3_accepted", 32'(acc), 8);
        repeat (6) tick();
        @(negedge clk);
        check("t3_ready_low", 32'(o_issue_ready), 0);
        check("t3_count_full", 32'(o_count), 8);
        check("t3_no_ovf", 32'(o_overflow), 0);

        // 4: drain while issuing every cycle, across pointer wrap
        pops0 = n_pops;
        tick();
        i_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t4_ready_after_pop", 32'(o_issue_ready), 1);
        check("t4_count7", 32'(o_count), 7);
        tick();
        acc = 0;
        for (int i = 0; i < 24; i++) begin
            op_a = 16'hA000 + 16'(i * 16'h0101);
            op_b = 16'h7000 - 16'(i * 16'h0203);
            i_issue_valid = 1'b1;
            if (o_issue_ready) acc++;
            tick();
        end
        i_issue_valid = 1'b0;
        check("t4_issue_every_cycle", 32'(acc), 24);
        repeat (10) tick();
        @(negedge clk);
        check("t4_pops", 32'(n_pops - pops0), 32);
        check("t4_drained", 32'(o_count), 0);
        check("t4_sb_empty", 32'(sb.size()), 0);
        check("t4_no_ovf", 32'(o_overflow), 0);

        // 5: forced issue without credit
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op_a = 16'h0F00 + 16'(i);
            op_b = 16'h00F0 + 16'(i * 3);
            i_issue_valid = o_issue_ready;
            tick();
        end
        i_issue_valid = 1'b0;
        repeat (6) tick();
        op_a = 16'h5555; op_b = 16'h5555; i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        check("t5_ovf_set", 32'(o_overflow), 1);
        check("t5_count_unchanged", 32'(o_count), 8);
        tick();
        i_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("t5_drained", 32'(o_count), 0);
        check("t5_sb_empty", 32'(sb.size()), 0);
        check("t5_ovf_sticky", 32'(o_overflow), 1);

        // 6: reset with 3 in flight and 2 buffered
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op_a = 16'h2000 + 16'(i); op_b = 16'h0100; i_issue_valid = 1'b1;
            tick();
        end
        i_issue_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("t6_buffered", 32'(o_count), 2);
        tick();
        i_rst = 1'b1;
        sb.delete();
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        check("t6_valid_cleared", 32'(o_valid), 0);
        check("t6_count_cleared", 32'(o_count), 0);
        check("t6_ovf_cleared", 32'(o_overflow), 0);
        check("t6_ready", 32'(o_issue_ready), 1);
        tick();
        i_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("t6_no_stale", 32'(o_count), 0);
        pops0 = n_pops;
        tick();
        i_ready = 1'b0;
        op_a = 16'h4321; op_b = 16'h1111; i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t6_new_sum", 32'(o_sum), 32'h5432);
        check("t6_new_cout", 32'(o_c_out), 0);
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        @(negedge clk);
        check("t6_new_popped", 32'(n_pops - pops0), 1);
        check("t6_sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
